// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: control sequencer for fetch and execution of register-register
// ALU instructions. Drives the datapath strobes from a single state register
// plus fields latched in DEC; all outputs are registered (Moore).
module alu_ctrl_seq #(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [12:0]         alu_op
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, DEC, T3, T4, T5, T6, DONE
  } state_t;

  typedef enum logic [1:0] {
    CL_NONE, CL_3OP, CL_HL, CL_1OP
  } class_t;

  state_t     state, state_n;
  class_t     cls, cls_n;
  logic [4:0] op, op_n;
  logic [3:0] ra, ra_n, rb, rb_n, rc, rc_n;
  logic       bad, bad_n;

  // Registered output next-values
  logic                busy_n, done_n, illegal_n;
  logic [NUM_REGS-1:0] rin_n, rout_n;
  logic                pc_out_n, pc_in_n, inc_pc_n, mar_in_n, read_n, mdr_in_n;
  logic                mdr_out_n, ir_in_n, y_in_n, z_in_n, zlow_out_n, zhigh_out_n;
  logic                hi_in_n, lo_in_n;
  logic [12:0]         alu_op_n;

  // Low IR bits carry no meaning for this instruction format
  logic ir_unused;
  assign ir_unused = ^ir[14:0];

  function automatic class_t op_class(input logic [4:0] o);
    case (o)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: op_class = CL_3OP;
      5'b01111, 5'b10000:                     op_class = CL_HL;
      5'b10001, 5'b10010:                     op_class = CL_1OP;
      default:                                op_class = CL_NONE;
    endcase
  endfunction

  function automatic logic [12:0] op_alu(input logic [4:0] o);
    case (o)
      5'b00101: op_alu = 13'h0001; // AND
      5'b00110: op_alu = 13'h0002; // OR
      5'b00011: op_alu = 13'h0004; // ADD
      5'b00100: op_alu = 13'h0008; // SUB
      5'b01111: op_alu = 13'h0010; // MUL
      5'b10000: op_alu = 13'h0020; // DIV
      5'b01001: op_alu = 13'h0040; // SHR
      5'b01010: op_alu = 13'h0080; // SHRA
      5'b01011: op_alu = 13'h0100; // SHL
      5'b00111: op_alu = 13'h0200; // ROR
      5'b01000: op_alu = 13'h0400; // ROL
      5'b10001: op_alu = 13'h0800; // NEG
      5'b10010: op_alu = 13'h1000; // NOT
      default:  op_alu = '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [3:0] f);
    in_range = ({1'b0, f} < 5'(NUM_REGS));
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) onehot[i] = 1'b1;
    end
  endfunction

  // Next state and field latching; fields only load from ir while in DEC
  always_comb begin
    state_n = state;
    cls_n   = cls;
    op_n    = op;
    ra_n    = ra;
    rb_n    = rb;
    rc_n    = rc;
    bad_n   = bad;
    case (state)
      IDLE: if (start) state_n = T0;
      T0:   state_n = T1;
      T1:   if (mem_ready) state_n = T2;
      T2:   state_n = DEC;
      DEC: begin
        op_n  = ir[31:27];
        ra_n  = ir[26:23];
        rb_n  = ir[22:19];
        rc_n  = ir[18:15];
        cls_n = op_class(ir[31:27]);
        case (cls_n)
          CL_3OP:  bad_n = !(in_range(ra_n) && in_range(rb_n) && in_range(rc_n));
          CL_HL:   bad_n = !(in_range(rb_n) && in_range(rc_n));
          CL_1OP:  bad_n = !(in_range(ra_n) && in_range(rb_n));
          default: bad_n = 1'b1;
        endcase
        state_n = bad_n ? DONE : T3;
      end
      T3:      state_n = (cls == CL_1OP) ? T5 : T4;
      T4:      state_n = T5;
      T5:      state_n = (cls == CL_HL) ? T6 : DONE;
      T6:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobe decode for the upcoming state, so registered outputs line up with it
  always_comb begin
    busy_n      = (state_n != IDLE);
    done_n      = 1'b0;
    illegal_n   = 1'b0;
    rin_n       = '0;
    rout_n      = '0;
    pc_out_n    = 1'b0;
    pc_in_n     = 1'b0;
    inc_pc_n    = 1'b0;
    mar_in_n    = 1'b0;
    read_n      = 1'b0;
    mdr_in_n    = 1'b0;
    mdr_out_n   = 1'b0;
    ir_in_n     = 1'b0;
    y_in_n      = 1'b0;
    z_in_n      = 1'b0;
    zlow_out_n  = 1'b0;
    zhigh_out_n = 1'b0;
    hi_in_n     = 1'b0;
    lo_in_n     = 1'b0;
    alu_op_n    = '0;
    case (state_n)
      T0: begin
        pc_out_n = 1'b1;
        mar_in_n = 1'b1;
        inc_pc_n = 1'b1;
        z_in_n   = 1'b1;
      end
      T1: begin
        zlow_out_n = 1'b1;
        read_n     = 1'b1;
        mdr_in_n   = 1'b1;
        pc_in_n    = (state != T1);
      end
      T2: begin
        mdr_out_n = 1'b1;
        ir_in_n   = 1'b1;
      end
      T3: begin
        rout_n = onehot(rb_n);
        if (cls_n == CL_1OP) begin
          alu_op_n = op_alu(op_n);
          z_in_n   = 1'b1;
        end else begin
          y_in_n = 1'b1;
        end
      end
      T4: begin
        rout_n   = onehot(rc_n);
        alu_op_n = op_alu(op_n);
        z_in_n   = 1'b1;
      end
      T5: begin
        zlow_out_n = 1'b1;
        if (cls_n == CL_HL) lo_in_n = 1'b1;
        else                rin_n   = onehot(ra_n);
      end
      T6: begin
        zhigh_out_n = 1'b1;
        hi_in_n     = 1'b1;
      end
      DONE: begin
        done_n    = 1'b1;
        illegal_n = bad_n;
      end
      default: ;
    endcase
  end

  // State, latched fields and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cls      <= CL_NONE;
      op       <= '0;
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
      bad      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      Rin      <= '0;
      Rout     <= '0;
      PCout    <= 1'b0;
      PCin     <= 1'b0;
      IncPC    <= 1'b0;
      MARin    <= 1'b0;
      Read     <= 1'b0;
      MDRin    <= 1'b0;
      MDRout   <= 1'b0;
      IRin     <= 1'b0;
      Yin      <= 1'b0;
      Zin      <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      alu_op   <= '0;
    end else begin
      state    <= state_n;
      cls      <= cls_n;
      op       <= op_n;
      ra       <= ra_n;
      rb       <= rb_n;
      rc       <= rc_n;
      bad      <= bad_n;
      busy     <= busy_n;
      done     <= done_n;
      illegal  <= illegal_n;
      Rin      <= rin_n;
      Rout     <= rout_n;
      PCout    <= pc_out_n;
      PCin     <= pc_in_n;
      IncPC    <= inc_pc_n;
      MARin    <= mar_in_n;
      Read     <= read_n;
      MDRin    <= mdr_in_n;
      MDRout   <= mdr_out_n;
      IRin     <= ir_in_n;
      Yin      <= y_in_n;
      Zin      <= z_in_n;
      Zlowout  <= zlow_out_n;
      Zhighout <= zhigh_out_n;
      HIin     <= hi_in_n;
      LOin     <= lo_in_n;
      alu_op   <= alu_op_n;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: per-cycle expected output snapshots from a
// table of instructions, plus hand sequences for reset/start corner cases.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic [15:0] rin, rout;
  logic        pc_out, pc_in, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
  logic [12:0] alu_op;

  logic        s8_start;
  logic [31:0] s8_ir;
  logic        s8_busy, s8_done, s8_illegal;
  logic [7:0]  s8_rin, s8_rout;
  logic        s8_pc_out, s8_pc_in, s8_inc_pc, s8_mar_in, s8_rd, s8_mdr_in, s8_mdr_out;
  logic        s8_ir_in, s8_y_in, s8_z_in, s8_zlo_out, s8_zhi_out, s8_hi_in, s8_lo_in;
  logic [12:0] s8_alu_op;

  alu_ctrl_seq #(.NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal), .Rin(rin), .Rout(rout),
    .PCout(pc_out), .PCin(pc_in), .IncPC(inc_pc), .MARin(mar_in), .Read(rd),
    .MDRin(mdr_in), .MDRout(mdr_out), .IRin(ir_in), .Yin(y_in), .Zin(z_in),
    .Zlowout(zlo_out), .Zhighout(zhi_out), .HIin(hi_in), .LOin(lo_in), .alu_op(alu_op)
  );

  alu_ctrl_seq #(.NUM_REGS(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .mem_ready(1'b1), .ir(s8_ir),
    .busy(s8_busy), .done(s8_done), .illegal(s8_illegal), .Rin(s8_rin), .Rout(s8_rout),
    .PCout(s8_pc_out), .PCin(s8_pc_in), .IncPC(s8_inc_pc), .MARin(s8_mar_in), .Read(s8_rd),
    .MDRin(s8_mdr_in), .MDRout(s8_mdr_out), .IRin(s8_ir_in), .Yin(s8_y_in), .Zin(s8_z_in),
    .Zlowout(s8_zlo_out), .Zhighout(s8_zhi_out), .HIin(s8_hi_in), .LOin(s8_lo_in),
    .alu_op(s8_alu_op)
  );

  typedef struct packed {
    logic        busy, done, illegal;
    logic [15:0] rin, rout;
    logic        pc_out, pc_in, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
    logic [12:0] alu;
  } outs_t;

  localparam int C_ILL = 0, C_3OP = 1, C_1OP = 2, C_HL = 3;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          stall;
    int          cls;
    logic [12:0] alu;
    int          ra, rb, rc;
  } vec_t;

  outs_t exp_q[$];
  vec_t  vecs[12];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic outs_t sample();
    outs_t o;
    o.busy = busy; o.done = done; o.illegal = illegal;
    o.rin = rin; o.rout = rout;
    o.pc_out = pc_out; o.pc_in = pc_in; o.inc_pc = inc_pc; o.mar_in = mar_in;
    o.rd = rd; o.mdr_in = mdr_in; o.mdr_out = mdr_out; o.ir_in = ir_in;
    o.y_in = y_in; o.z_in = z_in; o.zlo_out = zlo_out; o.zhi_out = zhi_out;
    o.hi_in = hi_in; o.lo_in = lo_in; o.alu = alu_op;
    return o;
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, input int st,
                              input int c, input logic [12:0] a,
                              input int ra, input int rb, input int rc);
    vec_t v;
    v.name = n; v.ir = i; v.stall = st; v.cls = c; v.alu = a;
    v.ra = ra; v.rb = rb; v.rc = rc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected snapshot for every cycle from T0 through DONE, then one IDLE cycle
  task automatic push_exp(input vec_t v);
    outs_t e;
    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    exp_q.push_back(e);
    for (int s = 0; s <= v.stall; s++) begin
      e = '0; e.busy = 1; e.zlo_out = 1; e.rd = 1; e.mdr_in = 1; e.pc_in = (s == 0);
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
    exp_q.push_back(e);
    e = '0; e.busy = 1;
    exp_q.push_back(e);
    if (v.cls != C_ILL) begin
      e = '0; e.busy = 1; e.rout = 16'd1 << v.rb;
      if (v.cls == C_1OP) begin e.alu = v.alu; e.z_in = 1; end
      else e.y_in = 1;
      exp_q.push_back(e);
      if (v.cls != C_1OP) begin
        e = '0; e.busy = 1; e.rout = 16'd1 << v.rc; e.alu = v.alu; e.z_in = 1;
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1; e.zlo_out = 1;
      if (v.cls == C_HL) e.lo_in = 1;
      else e.rin = 16'd1 << v.ra;
      exp_q.push_back(e);
      if (v.cls == C_HL) begin
        e = '0; e.busy = 1; e.zhi_out = 1; e.hi_in = 1;
        exp_q.push_back(e);
      end
    end
    e = '0; e.busy = 1; e.done = 1; e.illegal = (v.cls == C_ILL);
    exp_q.push_back(e);
    e = '0;
    exp_q.push_back(e);
  endtask

  // ir carries the instruction only in the DEC cycle; mem_ready is random outside T1
  task automatic run_vec(input vec_t v);
    int c;
    outs_t got, exp;
    push_exp(v);
    step();
    start = 1'b1; ir = $urandom(); mem_ready = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (exp_q.size() != 0) begin
      ir = (c == 4 + v.stall) ? v.ir : $urandom();
      if (c >= 2 && c < 2 + v.stall) mem_ready = 1'b0;
      else if (c == 2 + v.stall)     mem_ready = 1'b1;
      else                           mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = sample();
      exp = exp_q.pop_front();
      check($sformatf("%s c%0d", v.name, c), 64'(got), 64'(exp));
      step();
      c++;
    end
    mem_ready = 1'b1;
  endtask

  task automatic run8(input string name, input logic [31:0] i, input int exp_cycle,
                      input logic exp_ill);
    int   dc;
    logic ill, rin_seen, zhl_seen;
    dc = 0; ill = 0; rin_seen = 0; zhl_seen = 0;
    step();
    s8_start = 1'b1; s8_ir = i;
    step();
    s8_start = 1'b0;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      @(negedge clk);
      if (|s8_rin) rin_seen = 1;
      if (c >= 3 && (s8_z_in || s8_hi_in || s8_lo_in)) zhl_seen = 1;
      if (s8_done) begin dc = c; ill = s8_illegal; end
      step();
    end
    check({name, " done_cycle"}, 64'(dc), 64'(exp_cycle));
    check({name, " illegal"}, 64'(ill), 64'(exp_ill));
    check({name, " rin_seen"}, 64'(rin_seen), 64'd0);
    check({name, " zhl_seen"}, 64'(zhl_seen), 64'(!exp_ill));
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && busy; k++) step();
    check("drain busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    d1, t0b, d2;
    logic  busy_after;
    outs_t o;

    reset = 1'b0; start = 1'b0; mem_ready = 1'b1; ir = '0;
    s8_start = 1'b0; s8_ir = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", 64'(sample()), 64'd0);
    check("reset dut8 busy", 64'(s8_busy), 64'd0);
    reset = 1'b1;

    vecs[0]  = mk("AND R4,R3,R7",   32'h2A1B8000, 0, C_3OP, 13'h0001, 4, 3, 7);
    vecs[1]  = mk("MUL R3,R7",      32'h781B8000, 0, C_HL,  13'h0010, 0, 3, 7);
    vecs[2]  = mk("NEG R4,R3",      32'h8A180000, 0, C_1OP, 13'h0800, 4, 3, 0);
    vecs[3]  = mk("AND stall3",     32'h2A1B8000, 3, C_3OP, 13'h0001, 4, 3, 7);
    vecs[4]  = mk("ILL op00000",    32'h00000000, 0, C_ILL, 13'h0000, 0, 0, 0);
    vecs[5]  = mk("ADD R0,R15,R1",  32'h18788000, 0, C_3OP, 13'h0004, 0, 15, 1);
    vecs[6]  = mk("DIV R2,R5",      32'h80128000, 0, C_HL,  13'h0020, 0, 2, 5);
    vecs[7]  = mk("NOT R15,R14",    32'h97F00000, 0, C_1OP, 13'h1000, 15, 14, 0);
    vecs[8]  = mk("ROL stall1",     32'h40918000, 1, C_3OP, 13'h0400, 1, 2, 3);
    vecs[9]  = mk("ILL op11111 st2",32'hF8000000, 2, C_ILL, 13'h0000, 0, 0, 0);
    vecs[10] = mk("SHRA R5,R6,R7",  32'h52B38000, 0, C_3OP, 13'h0080, 5, 6, 7);
    vecs[11] = mk("ILL op01100",    32'h60000000, 0, C_ILL, 13'h0000, 0, 0, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Register-range legality on an 8-register instance
    run8("n8 AND Rb=9", 32'h2A4B8000, 5, 1'b1);
    run8("n8 MUL Ra=9", 32'h7C9B8000, 9, 1'b0);

    // Reset asserted during T4
    step();
    start = 1'b1; ir = 32'h2A1B8000;
    step();
    start = 1'b0;
    repeat (5) step();
    @(negedge clk);
    o = sample();
    check("pre-reset T4 alu", 64'(o.alu), 64'h0001);
    #1;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("reset in T4 outs", 64'(sample()), 64'd0);
    step();
    @(negedge clk);
    check("after reset idle busy", 64'(busy), 64'd0);

    // start pulses while busy are ignored
    step();
    start = 1'b1; ir = 32'h2A1B8000;
    step();
    d1 = 0; busy_after = 0;
    for (int c = 1; c <= 11; c++) begin
      start = (c == 3 || c == 8);
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      if (c >= 9 && busy) busy_after = 1;
      step();
    end
    start = 1'b0;
    check("busy start done_cycle", 64'(d1), 64'd8);
    check("busy start no relaunch", 64'(busy_after), 64'd0);

    // start held high: back-to-back instructions
    step();
    start = 1'b1; ir = 32'h2A1B8000;
    step();
    d1 = 0; t0b = 0; d2 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      else if (done && d1 != 0 && d2 == 0) d2 = c;
      if (pc_out && d1 != 0 && t0b == 0) t0b = c;
      step();
    end
    start = 1'b0;
    check("held start first done", 64'(d1), 64'd8);
    check("held start second T0", 64'(t0b), 64'd10);
    check("held start second done", 64'(d2), 64'd17);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
